thor2023_dcache_wrq: RTL

- Parametrised data-cache write-port controller with a small store queue and store-into-fill byte merging.
- Arbitrates line fills, cacheable store hits and invalidates onto the single registered write port of the dcache data RAM.
- Sits between the memory-unit state machine and the dcache data arrays.
- Adds over the previous generation: N-way one-hot way select, queued stores, fill priority, merge of pending stores into an incoming fill, and invalidate kill.

---
 rtl/thor2023_cache_pkg.sv | 24 ++
 rtl/thor2023_dcache_wrq_merge.sv | 43 ++++
 rtl/thor2023_dcache_wrq.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/thor2023_cache_pkg.sv
// Shared types and helpers for the thor2023 data-cache write path.
package thor2023_cache_pkg;

    localparam int DCWQ_DEPTH_DEF = 4;
    localparam int DCWQ_WID_DEF   = 512;
    localparam int DCWQ_WAYS_DEF  = 4;
    localparam int DCWQ_ADDR_DEF  = 32;

    // Store-queue entry laid out at the default cache geometry.
    typedef struct packed {
        logic                      live;
        logic [DCWQ_ADDR_DEF-1:0]  adr;
        logic [DCWQ_WAYS_DEF-1:0]  way;
        logic [DCWQ_WID_DEF/8-1:0] sel;
        logic [DCWQ_WID_DEF-1:0]   data;
    } dcwq_entry_t;

    // Same cache line: compares only the bits above the line offset.
    function automatic logic dcwq_line_eq(input logic [63:0] a, input logic [63:0] b,
                                          input int ofs_w);
        return ((a ^ b) >> ofs_w) == 64'd0;
    endfunction

endpackage

// File: rtl/thor2023_dcache_wrq_merge.sv
// Overlays queued stores (oldest first) and an optional same-cycle store onto fill data.
module thor2023_dcache_wrq_merge #(
    parameter int WID   = 512,
    parameter int DEPTH = 4
) (
    input  logic [WID-1:0]           fill_data,
    input  logic [WID/8-1:0]         ent_sel  [DEPTH],
    input  logic [WID-1:0]           ent_data [DEPTH],
    input  logic [DEPTH-1:0]         match,
    input  logic [$clog2(DEPTH)-1:0] head,
    input  logic                     st_v,
    input  logic [WID/8-1:0]         st_sel,
    input  logic [WID-1:0]           st_data,
    output logic [WID-1:0]           merged,
    output logic [DEPTH-1:0]         kill
);
    localparam int NB    = WID / 8;
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    always_comb begin
        merged = fill_data;
        idx    = head;
        // Walk from the head so younger stores land on top of older ones.
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (match[idx]) begin
                for (int b = 0; b < NB; b++) begin
                    if (ent_sel[idx][b]) merged[8*b +: 8] = ent_data[idx][8*b +: 8];
                end
            end
        end
        if (st_v) begin
            for (int b = 0; b < NB; b++) begin
                if (st_sel[b]) merged[8*b +: 8] = st_data[8*b +: 8];
            end
        end
    end

    assign kill = match;

endmodule

// File: rtl/thor2023_dcache_wrq.sv
// Dcache data-RAM write-port controller: fill priority, store queue with bypass,
// store-into-fill merging and invalidate kill.
module thor2023_dcache_wrq
    import thor2023_cache_pkg::*;
#(
    parameter int WID    = 512,
    parameter int WAYS   = 4,
    parameter int DEPTH  = DCWQ_DEPTH_DEF,
    parameter int ADDR_W = 32,
    parameter int OFS_W  = $clog2(WID/8)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fill_v,
    input  logic [ADDR_W-1:0]      fill_adr,
    input  logic [WAYS-1:0]        fill_way,
    input  logic [WID-1:0]         fill_data,
    input  logic                   st_v,
    output logic                   st_rdy,
    input  logic [ADDR_W-1:0]      st_adr,
    input  logic [WAYS-1:0]        st_way,
    input  logic [WID/8-1:0]       st_sel,
    input  logic [WID-1:0]         st_data,
    input  logic [3:0]             st_acr,
    input  logic                   inv_v,
    input  logic [ADDR_W-1:0]      inv_adr,
    output logic                   wr,
    output logic [WAYS-1:0]        wr_way,
    output logic [ADDR_W-1:0]      wr_adr,
    output logic [WID/8-1:0]       wr_sel,
    output logic [WID-1:0]         wr_data,
    output logic [$clog2(DEPTH):0] cnt,
    output logic                   busy
);
    localparam int NB    = WID / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFS_W) - ADDR_W'(1));

    logic [DEPTH-1:0]  q_live, live_nxt;
    logic [ADDR_W-1:0] q_adr  [DEPTH];
    logic [WAYS-1:0]   q_way  [DEPTH];
    logic [NB-1:0]     q_sel  [DEPTH];
    logic [WID-1:0]    q_data [DEPTH];
    logic [PTR_W-1:0]  head, tail;

    logic             st_acc, st_ok, st_eff, st_fill_hit;
    logic             q_empty, do_pop, do_push, do_bypass, head_live;
    logic [DEPTH-1:0] inv_hit, fill_hit, merge_kill;
    logic [WID-1:0]   merged;
    logic             unused_acr;

    // Only the cacheable bit matters here; the other rights are checked upstream.
    assign unused_acr = ^st_acr[2:0];

    assign st_rdy      = (cnt < CNT_FULL);
    assign st_acc      = st_v && st_rdy;
    assign st_ok       = st_acc && st_acr[3] && (st_sel != '0);
    assign st_eff      = st_ok && !(inv_v && dcwq_line_eq(64'(st_adr), 64'(inv_adr), OFS_W));
    assign st_fill_hit = fill_v && st_eff && dcwq_line_eq(64'(st_adr), 64'(fill_adr), OFS_W);
    assign q_empty     = (cnt == '0);
    assign do_pop      = !fill_v && !q_empty;
    assign do_bypass   = !fill_v && q_empty && st_eff;
    assign do_push     = st_eff && !st_fill_hit && !do_bypass;
    assign head_live   = q_live[head] && !inv_hit[head];

    always_comb begin
        inv_hit  = '0;
        fill_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            inv_hit[i]  = q_live[i] && inv_v &&
                          dcwq_line_eq(64'(q_adr[i]), 64'(inv_adr), OFS_W);
            fill_hit[i] = q_live[i] && !inv_hit[i] && fill_v &&
                          dcwq_line_eq(64'(q_adr[i]), 64'(fill_adr), OFS_W);
        end
    end

    thor2023_dcache_wrq_merge #(
        .WID   (WID),
        .DEPTH (DEPTH)
    ) u_merge (
        .fill_data (fill_data),
        .ent_sel   (q_sel),
        .ent_data  (q_data),
        .match     (fill_hit),
        .head      (head),
        .st_v      (st_fill_hit),
        .st_sel    (st_sel),
        .st_data   (st_data),
        .merged    (merged),
        .kill      (merge_kill)
    );

    always_comb begin
        live_nxt = q_live & ~inv_hit & ~merge_kill;
        if (do_pop)  live_nxt[head] = 1'b0;
        if (do_push) live_nxt[tail] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_live <= '0;
            head   <= '0;
            tail   <= '0;
            cnt    <= '0;
        end else begin
            q_live <= live_nxt;
            if (do_pop)  head <= head + PTR_W'(1);
            if (do_push) tail <= tail + PTR_W'(1);
            cnt <= cnt + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    // Payload needs no reset: nothing reads a slot whose live bit is clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            q_adr[tail]  <= st_adr & LINE_MASK;
            q_way[tail]  <= st_way;
            q_sel[tail]  <= st_sel;
            q_data[tail] <= st_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr      <= 1'b0;
            wr_way  <= '0;
            wr_adr  <= '0;
            wr_sel  <= '0;
            wr_data <= '0;
        end else if (fill_v) begin
            wr      <= 1'b1;
            wr_way  <= fill_way;
            wr_adr  <= fill_adr & LINE_MASK;
            wr_sel  <= '1;
            wr_data <= merged;
        end else if (do_pop) begin
            // A dead head still takes its pop slot, just without a write.
            wr <= head_live;
            if (head_live) begin
                wr_way  <= q_way[head];
                wr_adr  <= q_adr[head];
                wr_sel  <= q_sel[head];
                wr_data <= q_data[head];
            end
        end else if (do_bypass) begin
            wr      <= 1'b1;
            wr_way  <= st_way;
            wr_adr  <= st_adr & LINE_MASK;
            wr_sel  <= st_sel;
            wr_data <= st_data;
        end else begin
            wr <= 1'b0;
        end
    end

    assign busy = (cnt != '0) || wr;

endmodule
